// File: rtl/memory_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single-ported RAM.
// Each access is registered, held on the bus until ACCESS, then acknowledged with a one-cycle hit.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        merr
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     store_q, store_d;
  logic            wen_q, wen_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            last_d_q, last_d_d;
  logic [31:0]     iload_q, iload_d;
  logic [31:0]     dload_q, dload_d;
  logic            merr_q, merr_d;
  logic            dreq;
  logic            in_acc;

  assign dreq   = dREN | dWEN;
  assign in_acc = (state_q == IACC) || (state_q == DACC);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    wen_d      = wen_q;
    wait_cnt_d = wait_cnt_q;
    last_d_d   = last_d_q;
    iload_d    = iload_q;
    dload_d    = dload_q;
    merr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins unless fetch is waiting and data had the previous grant.
        if (dreq && (!iREN || !last_d_q)) begin
          state_d    = DACC;
          addr_d     = daddr;
          store_d    = dstore;
          wen_d      = dWEN;
          wait_cnt_d = '0;
          last_d_d   = 1'b1;
        end else if (iREN) begin
          state_d    = IACC;
          addr_d     = iaddr;
          store_d    = '0;
          wen_d      = 1'b0;
          wait_cnt_d = '0;
          last_d_d   = 1'b0;
        end
      end
      IACC, DACC: begin
        if (ramstate == RAM_ACCESS) begin
          if (state_q == IACC) begin
            iload_d = ramload;
            state_d = IRESP;
          end else begin
            if (!wen_q) dload_d = ramload;
            state_d = DRESP;
          end
        end else if ((ramstate == RAM_ERROR) || (wait_cnt_q == WAIT_LAST)) begin
          merr_d  = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      IRESP, DRESP: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      store_q    <= '0;
      wen_q      <= 1'b0;
      wait_cnt_q <= '0;
      last_d_q   <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
      merr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      wen_q      <= wen_d;
      wait_cnt_q <= wait_cnt_d;
      last_d_q   <= last_d_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      merr_q     <= merr_d;
    end
  end

  assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !wen_q);
  assign ramWEN   = (state_q == DACC) && wen_q;
  assign ramaddr  = in_acc ? addr_q : '0;
  assign ramstore = ((state_q == DACC) && wen_q) ? store_q : '0;
  assign ihit     = (state_q == IRESP);
  assign dhit     = (state_q == DRESP);
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign merr     = merr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected completions queued at request time,
// checked against hit/error pulses, plus cycle-exact checks of the RAM-side strobes.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic        ramREN, ramWEN, ihit, dhit, merr;
  logic [31:0] ramaddr, ramstore, iload, dload;

  typedef struct {
    logic [1:0]  kind;   // 0 fetch hit, 1 data hit, 2 error
    logic [31:0] data;
  } sb_t;

  sb_t          sb[$];
  sb_t          ent;
  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  int unsigned  busy_cnt = 0;
  int unsigned  acc_cyc = 0;
  logic         err_mode = 1'b0;
  logic [31:0]  rd_data = '0;
  logic [31:0]  alt_addr = 32'hFFFF_FFFC;
  logic [31:0]  alt_data = '0;
  logic [31:0]  exp_dload = '0;
  logic [1:0]   obs_kind;
  int unsigned  n, b;
  logic         is_d, is_w;

  memory_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .merr(merr)
  );

  always #5 CLK = ~CLK;

  // RAM model: BUSY for busy_cnt cycles of a strobe, then ACCESS (or ERROR when forced).
  assign ramstate = (ramREN | ramWEN)
                  ? (err_mode ? 2'd3 : ((acc_cyc < busy_cnt) ? 2'd1 : 2'd2))
                  : 2'd0;
  assign ramload  = (ramaddr == alt_addr) ? alt_data : rd_data;

  always @(posedge CLK) acc_cyc <= (ramREN | ramWEN) ? acc_cyc + 1 : 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] data);
    sb_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_evt(input string tag, input int unsigned limit, output int unsigned cnt);
    logic seen;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < limit) begin
      step();
      cnt++;
      seen = ihit | dhit | merr;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  // Completion monitor: every hit or error must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!nRST && (ihit | dhit | merr)) begin
      check("hit_excl", 64'(ihit & dhit), 64'd0);
      obs_kind = merr ? 2'd2 : (dhit ? 2'd1 : 2'd0);
      if (sb.size() == 0) begin
        check("sb_unexpected", 64'(obs_kind), 64'd3);
      end else begin
        ent = sb.pop_front();
        check("sb_kind", 64'(obs_kind), 64'(ent.kind));
        if (ent.kind == 2'd0) check("sb_iload", 64'(iload), 64'(ent.data));
        if (ent.kind == 2'd1) check("sb_dload", 64'(dload), 64'(ent.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    #1 nRST = 1'b1;
    repeat (2) step();
    check("rst_flags", 64'({ramREN, ramWEN, ihit, dhit, merr}), 64'd0);
    check("rst_ramaddr", 64'(ramaddr), 64'd0);
    check("rst_ramstore", 64'(ramstore), 64'd0);
    check("rst_iload", 64'(iload), 64'd0);
    check("rst_dload", 64'(dload), 64'd0);
    nRST = 1'b0;
    step();

    // Zero-wait fetch
    iREN = 1; iaddr = 32'h100; rd_data = 32'h8C01_0004;
    push(2'd0, 32'h8C01_0004);
    step();
    check("f_ren_c1", 64'(ramREN), 64'd1);
    check("f_addr_c1", 64'(ramaddr), 64'h100);
    check("f_ihit_c1", 64'(ihit), 64'd0);
    step();
    check("f_ihit_c2", 64'(ihit), 64'd1);
    check("f_iload_c2", 64'(iload), 64'h8C01_0004);
    check("f_ren_c2", 64'(ramREN), 64'd0);
    iREN = 0;
    step();
    check("f_ihit_c3", 64'(ihit), 64'd0);

    // Tie: data first, then fetch despite dREN held, then data again
    iREN = 1; iaddr = 32'h104; dREN = 1; daddr = 32'h200;
    rd_data = 32'hDEAD_BEEF; alt_addr = 32'h104; alt_data = 32'h1111_2222;
    push(2'd1, 32'hDEAD_BEEF);
    push(2'd0, 32'h1111_2222);
    push(2'd1, 32'hDEAD_BEEF);
    exp_dload = 32'hDEAD_BEEF;
    wait_evt("tie1", 10, n);
    check("tie1_dhit", 64'(dhit), 64'd1);
    wait_evt("tie2", 10, n);
    check("tie2_ihit", 64'(ihit), 64'd1);
    iREN = 0;
    wait_evt("tie3", 10, n);
    check("tie3_dhit", 64'(dhit), 64'd1);
    dREN = 0;
    alt_addr = 32'hFFFF_FFFC;
    step();

    // Write with three BUSY cycles
    dWEN = 1; daddr = 32'h300; dstore = 32'h1234_5678; busy_cnt = 3; rd_data = 32'hBAD0_BAD0;
    push(2'd1, exp_dload);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("w_wen", 64'({ramWEN, ramREN}), 64'b10);
      check("w_store", 64'(ramstore), 64'h1234_5678);
      check("w_addr", 64'(ramaddr), 64'h300);
      check("w_nohit", 64'(dhit), 64'd0);
    end
    step();
    check("w_dhit_c5", 64'(dhit), 64'd1);
    check("w_strobe_c5", 64'({ramWEN, ramstore}), 64'd0);
    dWEN = 0; busy_cnt = 0;
    step();

    // Timeout with TIMEOUT=4
    dREN = 1; daddr = 32'h400; busy_cnt = 100;
    push(2'd2, '0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("to_ren", 64'({ramREN, merr}), 64'b10);
    end
    step();
    check("to_merr", 64'({merr, ramREN, dhit}), 64'b100);
    dREN = 0; busy_cnt = 0;
    step();
    check("to_idle", 64'({merr, ramREN, ramWEN, dhit}), 64'd0);

    // ERROR on first access cycle
    dREN = 1; daddr = 32'h404; err_mode = 1;
    push(2'd2, '0);
    step();
    check("er_ren", 64'({ramREN, merr}), 64'b10);
    step();
    check("er_merr", 64'({merr, ramREN, dhit}), 64'b100);
    dREN = 0; err_mode = 0;
    step();
    check("er_clear", 64'(merr), 64'd0);

    // Reset in the middle of a stalled data access
    dREN = 1; daddr = 32'h500; busy_cnt = 100;
    step();
    check("rm_ren", 64'(ramREN), 64'd1);
    step();
    #2 nRST = 1'b1;
    dREN = 0;
    #1;
    check("rm_flags", 64'({ramREN, ramWEN, ihit, dhit, merr}), 64'd0);
    check("rm_addr", 64'(ramaddr), 64'd0);
    check("rm_dload", 64'(dload), 64'd0);
    exp_dload = '0;
    step();
    nRST = 1'b0;
    busy_cnt = 0;
    repeat (3) step();
    check("rm_quiet", 64'({ramREN, dhit, merr}), 64'd0);
    dREN = 1; rd_data = 32'hCAFE_0500;
    push(2'd1, 32'hCAFE_0500);
    exp_dload = 32'hCAFE_0500;
    step();
    check("rr_ren", 64'({ramREN, ramaddr}), {1'b1, 32'h500});
    step();
    check("rr_dhit", 64'(dhit), 64'd1);
    dREN = 0;
    step();

    // Random single requests: latency must be 2 + BUSY cycles
    for (int i = 0; i < 10; i++) begin
      is_d = 1'($urandom_range(0, 1));
      is_w = is_d & 1'($urandom_range(0, 1));
      b = $urandom_range(0, 2);
      busy_cnt = b;
      rd_data = $urandom;
      if (!is_d) begin
        push(2'd0, rd_data);
        iREN = 1; iaddr = $urandom;
      end else if (is_w) begin
        push(2'd1, exp_dload);
        dWEN = 1; daddr = $urandom; dstore = $urandom;
      end else begin
        exp_dload = rd_data;
        push(2'd1, rd_data);
        dREN = 1; daddr = $urandom;
      end
      wait_evt("rnd", 10, n);
      check("rnd_latency", 64'(n), 64'(2 + b));
      iREN = 0; dREN = 0; dWEN = 0;
      step();
    end

    repeat (3) step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
